// File: rtl/ecap_pkg.sv
// Shared constants for the ecap_array capture unit.
// These cover the register map, the global addresses and the STATUS/CTRL bit positions.
package ecap_pkg;

  typedef enum logic [1:0] {
    RegPeriod = 2'd0,
    RegHigh   = 2'd1,
    RegStatus = 2'd2,
    RegCtrl   = 2'd3
  } reg_off_e;

  localparam logic [7:0]  ADDR_ID       = 8'hF0;
  localparam logic [7:0]  ADDR_IRQ_PEND = 8'hF1;
  localparam logic [15:0] ID_BASE       = 16'hEC00;

  localparam int unsigned ST_NEW      = 0;
  localparam int unsigned ST_OVF      = 1;
  localparam int unsigned ST_STALL    = 2;
  localparam int unsigned ST_LEVEL    = 3;
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned MAX_CH = 8;

endpackage

// File: rtl/ecap_channel.sv
// One capture channel: it synchronises, filters and edge-detects its pin, then measures
// period and high time with a saturating counter.
module ecap_channel
  import ecap_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned FILT  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_cap,
  input  logic        i_ctrl_we,
  input  logic [1:0]  i_ctrl_wdata,
  input  logic        i_stat_we,
  input  logic [1:0]  i_stat_w1c,
  output logic [15:0] o_period,
  output logic [15:0] o_high,
  output logic [3:0]  o_status,
  output logic [1:0]  o_ctrl
);

  logic [1:0]       r_sync;
  logic             w_level;
  logic             r_prev;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hpend;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_primed;
  logic             r_new;
  logic             r_ovf;
  logic             r_stall;
  logic             r_en;
  logic             r_irq_en;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_p1;

  always_ff @(posedge CLK) begin
    if (RESET) r_sync <= '0;
    else       r_sync <= {r_sync[0], i_cap};
  end

  if (FILT == 0) begin : g_nofilt
    assign w_level = r_sync[1];
  end else begin : g_filt
    localparam int unsigned FW = (FILT < 2) ? 1 : $clog2(FILT + 1);
    logic [FW-1:0] r_fcnt;
    logic          r_filt;

    // The level flips once the synchronised input has disagreed for FILT straight cycles.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_fcnt <= '0;
        r_filt <= 1'b0;
      end else if (r_sync[1] == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILT - 1)) begin
        r_fcnt <= '0;
        r_filt <= r_sync[1];
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
    assign w_level = r_filt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign w_cnt_sat = &r_cnt;
  assign w_cnt_p1  = w_cnt_sat ? r_cnt : r_cnt + 1'b1;

  // Later assignments override earlier ones, so an event beats a same-cycle W1C.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_hpend  <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_primed <= 1'b0;
      r_new    <= 1'b0;
      r_ovf    <= 1'b0;
      r_stall  <= 1'b0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (i_ctrl_we) begin
        r_en     <= i_ctrl_wdata[CTRL_EN];
        r_irq_en <= i_ctrl_wdata[CTRL_IRQ_EN];
      end
      if (i_stat_we) begin
        if (i_stat_w1c[ST_NEW]) r_new <= 1'b0;
        if (i_stat_w1c[ST_OVF]) r_ovf <= 1'b0;
      end
      if (!r_en) begin
        r_cnt    <= '0;
        r_primed <= 1'b0;
        r_hpend  <= '0;
      end else begin
        if (w_cnt_sat) r_ovf <= 1'b1;
        if (r_rise) begin
          r_cnt    <= '0;
          r_primed <= 1'b1;
          r_stall  <= 1'b0;
          if (r_primed) begin
            r_period <= w_cnt_p1;
            r_high   <= r_hpend;
            r_new    <= 1'b1;
          end
        end else begin
          r_cnt <= w_cnt_p1;
          if (r_fall) r_hpend <= w_cnt_p1;
          if (w_cnt_sat && r_primed) r_stall <= 1'b1;
        end
      end
    end
  end

  assign o_period = 16'(r_period);
  assign o_high   = 16'(r_high);
  assign o_status = {w_level, r_stall, r_ovf, r_new};
  assign o_ctrl   = {r_irq_en, r_en};

endmodule

// File: rtl/ecap_array.sv
// Multi-channel input-capture unit: it decodes the register bus, muxes read data
// and drives the registered interrupt.
module ecap_array
  import ecap_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned FILT  = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] cap_in,
  input  logic [7:0]      bus_addr,
  input  logic            bus_wr,
  input  logic [15:0]     bus_wdata,
  input  logic            bus_rd,
  output logic [15:0]     bus_rdata,
  output logic            irq
);

  logic [15:0]       w_period [MAX_CH];
  logic [15:0]       w_high   [MAX_CH];
  logic [3:0]        w_status [MAX_CH];
  logic [1:0]        w_ctrl   [MAX_CH];
  logic [MAX_CH-1:0] w_ctrl_we;
  logic [MAX_CH-1:0] w_stat_we;
  logic [MAX_CH-1:0] w_pend;
  logic              w_ch_hit;
  logic [2:0]        w_ch_sel;
  reg_off_e          w_off;
  logic [15:0]       w_rd_mux;
  logic [15:0]       r_rdata;
  logic              r_irq;
  logic              w_unused_wdata;

  assign w_ch_hit       = bus_addr < 8'(4 * N_CH);
  assign w_ch_sel       = bus_addr[4:2];
  assign w_off          = reg_off_e'(bus_addr[1:0]);
  assign w_unused_wdata = ^bus_wdata[15:2];

  always_comb begin
    w_ctrl_we = '0;
    w_stat_we = '0;
    w_pend    = '0;
    for (int c = 0; c < MAX_CH; c++) begin
      w_ctrl_we[c] = bus_wr & w_ch_hit & (w_ch_sel == 3'(c)) & (w_off == RegCtrl);
      w_stat_we[c] = bus_wr & w_ch_hit & (w_ch_sel == 3'(c)) & (w_off == RegStatus);
      w_pend[c]    = w_status[c][ST_NEW] & w_ctrl[c][CTRL_IRQ_EN];
    end
  end

  for (genvar c = 0; c < MAX_CH; c++) begin : g_ch
    if (c < N_CH) begin : g_on
      ecap_channel #(
        .CNT_W(CNT_W),
        .FILT (FILT)
      ) u_channel (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_cap       (cap_in[c]),
        .i_ctrl_we   (w_ctrl_we[c]),
        .i_ctrl_wdata(bus_wdata[1:0]),
        .i_stat_we   (w_stat_we[c]),
        .i_stat_w1c  (bus_wdata[1:0]),
        .o_period    (w_period[c]),
        .o_high      (w_high[c]),
        .o_status    (w_status[c]),
        .o_ctrl      (w_ctrl[c])
      );
    end else begin : g_off
      assign w_period[c] = '0;
      assign w_high[c]   = '0;
      assign w_status[c] = '0;
      assign w_ctrl[c]   = '0;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (bus_addr == ADDR_ID) begin
      w_rd_mux = ID_BASE | 16'(N_CH);
    end else if (bus_addr == ADDR_IRQ_PEND) begin
      w_rd_mux = 16'(w_pend);
    end else if (w_ch_hit) begin
      unique case (w_off)
        RegPeriod: w_rd_mux = w_period[w_ch_sel];
        RegHigh:   w_rd_mux = w_high[w_ch_sel];
        RegStatus: w_rd_mux = {12'b0, w_status[w_ch_sel]};
        RegCtrl:   w_rd_mux = {14'b0, w_ctrl[w_ch_sel]};
        default:   w_rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (bus_rd) r_rdata <= w_rd_mux;
      r_irq <= |w_pend;
    end
  end

  assign bus_rdata = r_rdata;
  assign irq       = r_irq;

endmodule

// File: tb/tb_ecap_array.sv
// Bench for ecap_array (4 channels, 8-bit counters, 2-cycle filter): directed scenarios
// followed by random square waves checked against a period/high-time model.
module tb_ecap_array;

  localparam int unsigned NCh  = 4;
  localparam int unsigned CntW = 8;
  localparam int unsigned Filt = 2;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [NCh-1:0] cap_in;
  logic [7:0]     bus_addr;
  logic           bus_wr;
  logic [15:0]    bus_wdata;
  logic           bus_rd;
  logic [15:0]    bus_rdata;
  logic           irq;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_period [NCh];
  logic [15:0] exp_high   [NCh];

  ecap_array #(
    .N_CH (NCh),
    .CNT_W(CntW),
    .FILT (Filt)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .cap_in   (cap_in),
    .bus_addr (bus_addr),
    .bus_wr   (bus_wr),
    .bus_wdata(bus_wdata),
    .bus_rd   (bus_rd),
    .bus_rdata(bus_rdata),
    .irq      (irq)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    step(1);
    bus_wr = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [15:0] expv);
    bus_addr = a;
    bus_rd   = 1'b1;
    step(1);
    bus_rd = 1'b0;
    check(tag, bus_rdata, expv);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    RESET     = 1'b1;
    cap_in    = '0;
    bus_addr  = '0;
    bus_wr    = 1'b0;
    bus_wdata = '0;
    bus_rd    = 1'b0;
    step(3);
    RESET = 1'b0;
    step(1);

    // Reset state
    check("rst_rdata", bus_rdata, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    read_chk("rst_period0", 8'h00, 16'h0000);
    read_chk("rst_status0", 8'h02, 16'h0000);
    read_chk("rst_ctrl0", 8'h03, 16'h0000);
    read_chk("rst_id", 8'hF0, 16'hEC04);
    read_chk("rst_pend", 8'hF1, 16'h0000);

    // Square wave on ch0: period 100, high 30
    bus_write(8'h03, 16'h0001);
    step(10);
    cap_in[0] = 1'b1; step(30);
    cap_in[0] = 1'b0; step(70);
    cap_in[0] = 1'b1; step(8);
    read_chk("sq_period", 8'h00, 16'd100);
    read_chk("sq_high", 8'h01, 16'd30);
    read_chk("sq_status", 8'h02, 16'h0009);
    bus_write(8'h00, 16'h1234);
    read_chk("sq_ro_period", 8'h00, 16'd100);
    read_chk("sq_new_kept", 8'h02, 16'h0009);
    bus_write(8'h20, 16'hFFFF);
    read_chk("unmapped", 8'h20, 16'h0000);
    bus_write(8'h02, 16'h0001);
    read_chk("sq_w1c", 8'h02, 16'h0008);
    step(3);
    check("rdata_hold", bus_rdata, 16'h0008);
    cap_in[0] = 1'b0;
    bus_write(8'h03, 16'h0000);
    step(10);

    // Glitch filter on ch1: 1-cycle glitches vanish, 3-cycle pulses pass
    bus_write(8'h07, 16'h0001);
    step(10);
    cap_in[1] = 1'b1; step(1);
    cap_in[1] = 1'b0; step(10);
    read_chk("gl_status", 8'h06, 16'h0000);
    cap_in[1] = 1'b1; step(3);
    cap_in[1] = 1'b0; step(12);
    cap_in[1] = 1'b1; step(1);
    cap_in[1] = 1'b0; step(24);
    cap_in[1] = 1'b1; step(3);
    cap_in[1] = 1'b0; step(10);
    read_chk("gl_period", 8'h04, 16'd40);
    read_chk("gl_high", 8'h05, 16'd3);
    read_chk("gl_status2", 8'h06, 16'h0001);
    bus_write(8'h07, 16'h0000);

    // Overflow and stall on ch3
    bus_write(8'h0F, 16'h0001);
    step(4);
    cap_in[3] = 1'b1; step(300);
    read_chk("ov_status", 8'h0E, 16'h000E);
    cap_in[3] = 1'b0; step(20);
    cap_in[3] = 1'b1; step(8);
    read_chk("ov_period", 8'h0C, 16'h00FF);
    read_chk("ov_high", 8'h0D, 16'h00FF);
    read_chk("ov_status2", 8'h0E, 16'h000B);
    cap_in[3] = 1'b0;
    bus_write(8'h0F, 16'h0000);

    // Interrupt on ch2
    bus_write(8'h0B, 16'h0003);
    step(4);
    cap_in[2] = 1'b1; step(20);
    cap_in[2] = 1'b0; step(30);
    cap_in[2] = 1'b1; step(8);
    check("irq_set", {15'b0, irq}, 16'h0001);
    read_chk("irq_pend", 8'hF1, 16'h0004);
    read_chk("irq_period", 8'h08, 16'd50);
    bus_write(8'h0A, 16'h0001);
    step(2);
    check("irq_clr", {15'b0, irq}, 16'h0000);
    read_chk("irq_status", 8'h0A, 16'h0008);
    cap_in[2] = 1'b0; step(20);
    cap_in[2] = 1'b1; step(5);
    // rise pulse is high during this write cycle
    bus_write(8'h0A, 16'h0001);
    step(3);
    read_chk("set_wins", 8'h0A, 16'h0009);
    check("irq_again", {15'b0, irq}, 16'h0001);
    read_chk("irq_period2", 8'h08, 16'd34);
    read_chk("irq_high2", 8'h09, 16'd14);
    cap_in[2] = 1'b0;
    bus_write(8'h0B, 16'h0000);

    // Disable mid-measurement on ch0
    bus_write(8'h03, 16'h0001);
    bus_write(8'h02, 16'h0003);
    step(4);
    cap_in[0] = 1'b1; step(20);
    bus_write(8'h03, 16'h0000);
    cap_in[0] = 1'b0; step(10);
    bus_write(8'h03, 16'h0001);
    step(5);
    cap_in[0] = 1'b1; step(8);
    read_chk("dis_first", 8'h02, 16'h0008);
    step(1);
    cap_in[0] = 1'b0; step(20);
    cap_in[0] = 1'b1; step(8);
    read_chk("dis_period", 8'h00, 16'd30);
    read_chk("dis_high", 8'h01, 16'd10);
    read_chk("dis_status", 8'h02, 16'h0009);
    cap_in[0] = 1'b0;
    bus_write(8'h03, 16'h0000);
    step(10);

    exp_period[0] = 16'd30;  exp_high[0] = 16'd10;
    exp_period[1] = 16'd40;  exp_high[1] = 16'd3;
    exp_period[2] = 16'd34;  exp_high[2] = 16'd14;
    exp_period[3] = 16'hFF;  exp_high[3] = 16'hFF;

    // Random square waves: latched values are the last complete period's durations
    for (int t = 0; t < 12; t++) begin
      int unsigned ch;
      int unsigned ie;
      int unsigned n;
      int unsigned hi;
      int unsigned lo;
      logic        nw;
      ch = $urandom_range(0, NCh - 1);
      ie = $urandom_range(0, 1);
      n  = $urandom_range(0, 3);
      bus_write(8'(4 * ch + 3), 16'(ie * 2 + 1));
      bus_write(8'(4 * ch + 2), 16'h0003);
      step(4);
      for (int i = 0; i < int'(n); i++) begin
        hi = $urandom_range(3, 110);
        lo = $urandom_range(3, 110);
        cap_in[ch] = 1'b1; step(hi);
        cap_in[ch] = 1'b0; step(lo);
        exp_period[ch] = 16'(hi + lo);
        exp_high[ch]   = 16'(hi);
      end
      cap_in[ch] = 1'b1; step($urandom_range(6, 15));
      cap_in[ch] = 1'b0; step(8);
      nw = (n > 0);
      read_chk("rnd_period", 8'(4 * ch), exp_period[ch]);
      read_chk("rnd_high", 8'(4 * ch + 1), exp_high[ch]);
      read_chk("rnd_status", 8'(4 * ch + 2), {15'b0, nw});
      read_chk("rnd_pend", 8'hF1, (nw && ie != 0) ? 16'(1 << ch) : 16'h0000);
      check("rnd_irq", {15'b0, irq}, {15'b0, nw && ie != 0});
      bus_write(8'(4 * ch + 3), 16'h0000);
    end

    // Reset in the middle of a measurement
    bus_write(8'h03, 16'h0003);
    bus_write(8'h0B, 16'h0003);
    cap_in[0] = 1'b1; step(20);
    cap_in[0] = 1'b0; step(1);
    RESET = 1'b1; step(2);
    RESET = 1'b0; step(1);
    check("mr_rdata", bus_rdata, 16'h0000);
    check("mr_irq", {15'b0, irq}, 16'h0000);
    read_chk("mr_period0", 8'h00, 16'h0000);
    read_chk("mr_high1", 8'h05, 16'h0000);
    read_chk("mr_status0", 8'h02, 16'h0000);
    read_chk("mr_ctrl2", 8'h0B, 16'h0000);
    read_chk("mr_period3", 8'h0C, 16'h0000);
    read_chk("mr_pend", 8'hF1, 16'h0000);
    read_chk("mr_id", 8'hF0, 16'hEC04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
